// File: rtl/ddr_judge.sv
// Rhythm-game hit judge: per-lane arrow state tracking, two-stage grading pipeline,
// and score/combo accumulation for four arrow lanes.
module ddr_judge #(
   parameter int unsigned CORDW       = 10,
   parameter int unsigned TARGET_Y    = 40,
   parameter int unsigned PERFECT_WIN = 4,
   parameter int unsigned GOOD_WIN    = 12,
   parameter int unsigned SCORE_W     = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 frame_i,
   input  logic [3:0]           press_i,
   input  logic [4*CORDW-1:0]   arrow_y_i,
   input  logic [3:0]           arrow_active_i,
   output logic [3:0]           hit_o,
   output logic [3:0]           miss_o,
   output logic                 grade_valid_o,
   output logic [1:0]           grade_o,
   output logic [SCORE_W-1:0]   score_o,
   output logic [7:0]           combo_o,
   output logic [7:0]           max_combo_o
);

   localparam int unsigned LANES = 4;
   localparam int unsigned DW    = CORDW + 1;
   localparam int unsigned BW    = CORDW + 2;
   localparam logic [DW-1:0]      TGT_D     = DW'(TARGET_Y);
   localparam logic [DW-1:0]      PERF_D    = DW'(PERFECT_WIN);
   localparam logic [DW-1:0]      GOOD_D    = DW'(GOOD_WIN);
   localparam logic [SCORE_W:0]   SCORE_MAX = {1'b0, {SCORE_W{1'b1}}};
   localparam logic [8:0]         COMBO_MAX = 9'd255;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LIVE   = 2'd1,
      JUDGED = 2'd2
   } lane_state_t;

   lane_state_t       r_state     [LANES];
   lane_state_t       w_state_nxt [LANES];

   logic [DW-1:0]     w_y         [LANES];
   logic [DW-1:0]     w_d         [LANES];
   logic [LANES-1:0]  w_below;

   logic [DW-1:0]     r_s1_d      [LANES];
   logic [LANES-1:0]  r_s1_press;
   logic [LANES-1:0]  r_s1_live;
   logic [LANES-1:0]  r_s1_below;
   logic              r_s1_frame;

   logic [LANES-1:0]  w_live;
   logic [LANES-1:0]  w_perf;
   logic [LANES-1:0]  w_good;
   logic [LANES-1:0]  w_hit;
   logic [LANES-1:0]  w_miss;
   logic [1:0]        w_grade;
   logic [4:0]        w_add;
   logic [2:0]        w_hit_cnt;
   logic [SCORE_W:0]  w_score_sum;
   logic [8:0]        w_combo_sum;

   logic [3:0]        r_hit;
   logic [3:0]        r_miss;
   logic              r_grade_valid;
   logic [1:0]        r_grade;
   logic [SCORE_W-1:0] r_score;
   logic [7:0]        r_combo;
   logic [7:0]        r_max_combo;

   // Stage-1 inputs: distance from the hit line and "scrolled past the good window".
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         w_y[l]     = DW'(arrow_y_i[l*CORDW +: CORDW]);
         w_d[l]     = (w_y[l] >= TGT_D) ? (w_y[l] - TGT_D) : (TGT_D - w_y[l]);
         w_below[l] = (BW'(w_y[l]) + BW'(GOOD_WIN)) < BW'(TARGET_Y);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int l = 0; l < int'(LANES); l++) begin
            r_s1_d[l] <= '0;
         end
         r_s1_press <= '0;
         r_s1_live  <= '0;
         r_s1_below <= '0;
         r_s1_frame <= 1'b0;
      end else begin
         for (int l = 0; l < int'(LANES); l++) begin
            r_s1_d[l]     <= w_d[l];
            r_s1_live[l]  <= (r_state[l] == LIVE);
         end
         r_s1_press <= press_i;
         r_s1_below <= w_below;
         r_s1_frame <= frame_i;
      end
   end

   // A lane judged on the previous edge is already JUDGED now, so a back-to-back press is dropped.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         w_live[l] = r_s1_live[l] && (r_state[l] == LIVE);
         w_perf[l] = r_s1_press[l] && w_live[l] && (r_s1_d[l] <= PERF_D);
         w_good[l] = r_s1_press[l] && w_live[l] && (r_s1_d[l] > PERF_D) && (r_s1_d[l] <= GOOD_D);
         w_hit[l]  = w_perf[l] || w_good[l];
         w_miss[l] = r_s1_frame && w_live[l] && r_s1_below[l] && !w_hit[l];
      end
   end

   always_comb begin
      w_grade   = 2'd0;
      w_add     = 5'd0;
      w_hit_cnt = 3'd0;
      for (int l = int'(LANES) - 1; l >= 0; l--) begin
         if (w_perf[l])      w_grade = 2'd3;
         else if (w_good[l]) w_grade = 2'd2;
         else if (w_miss[l]) w_grade = 2'd1;
      end
      for (int l = 0; l < int'(LANES); l++) begin
         w_add     = w_add + (w_perf[l] ? 5'd3 : 5'd0) + (w_good[l] ? 5'd1 : 5'd0);
         w_hit_cnt = w_hit_cnt + 3'(w_hit[l]);
      end
      w_score_sum = (SCORE_W+1)'(r_score) + (SCORE_W+1)'(w_add);
      if (w_score_sum > SCORE_MAX) w_score_sum = SCORE_MAX;
      w_combo_sum = 9'(r_combo) + 9'(w_hit_cnt);
      if (w_combo_sum > COMBO_MAX) w_combo_sum = COMBO_MAX;
      if (|w_miss) w_combo_sum = 9'd0;
   end

   // Lane FSM: deactivation overrides every other transition.
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         w_state_nxt[l] = r_state[l];
         case (r_state[l])
            IDLE:    if (arrow_active_i[l]) w_state_nxt[l] = LIVE;
            LIVE:    if (w_hit[l] || w_miss[l]) w_state_nxt[l] = JUDGED;
            default: w_state_nxt[l] = r_state[l];
         endcase
         if (!arrow_active_i[l]) w_state_nxt[l] = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int l = 0; l < int'(LANES); l++) begin
            r_state[l] <= IDLE;
         end
      end else begin
         for (int l = 0; l < int'(LANES); l++) begin
            r_state[l] <= w_state_nxt[l];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_hit         <= '0;
         r_miss        <= '0;
         r_grade_valid <= 1'b0;
         r_grade       <= 2'd0;
         r_score       <= '0;
         r_combo       <= '0;
         r_max_combo   <= '0;
      end else begin
         r_hit         <= w_hit;
         r_miss        <= w_miss;
         r_grade_valid <= |(w_hit | w_miss);
         r_grade       <= w_grade;
         r_score       <= w_score_sum[SCORE_W-1:0];
         r_combo       <= w_combo_sum[7:0];
         if (r_combo > r_max_combo) r_max_combo <= r_combo;
      end
   end

   assign hit_o         = r_hit;
   assign miss_o        = r_miss;
   assign grade_valid_o = r_grade_valid;
   assign grade_o       = r_grade;
   assign score_o       = r_score;
   assign combo_o       = r_combo;
   assign max_combo_o   = r_max_combo;

endmodule

// File: tb/tb_ddr_judge.sv
// Directed self-checking bench for ddr_judge with default parameters.
module tb_ddr_judge;

   localparam int unsigned CORDW = 10;

   logic                 clk;
   logic                 reset;
   logic                 frame;
   logic [3:0]           press;
   logic [4*CORDW-1:0]   arrow_y;
   logic [3:0]           arrow_active;
   logic [3:0]           hit;
   logic [3:0]           miss;
   logic                 grade_valid;
   logic [1:0]           grade;
   logic [15:0]          score;
   logic [7:0]           combo;
   logic [7:0]           max_combo;

   int n_checks = 0;
   int n_errors = 0;
   int exp_score;

   ddr_judge dut (
      .clk_i          (clk),
      .reset_i        (reset),
      .frame_i        (frame),
      .press_i        (press),
      .arrow_y_i      (arrow_y),
      .arrow_active_i (arrow_active),
      .hit_o          (hit),
      .miss_o         (miss),
      .grade_valid_o  (grade_valid),
      .grade_o        (grade),
      .score_o        (score),
      .combo_o        (combo),
      .max_combo_o    (max_combo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_y(input int lane, input int y);
      arrow_y[lane*CORDW +: CORDW] = CORDW'(y);
   endtask

   // Arm lanes, press them all, then retire them; outputs are visible on return.
   task automatic round(input logic [3:0] mask);
      arrow_active = mask;
      tick();
      press = mask;
      tick();
      press = 4'b0000;
      arrow_active = 4'b0000;
      tick();
   endtask

   initial begin
      reset = 1'b1;
      frame = 1'b0;
      press = 4'b0000;
      arrow_y = '0;
      arrow_active = 4'b0000;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_hit", 32'(hit), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_combo", 32'(combo), 0);
      chk("rst_grade", 32'(grade), 0);

      // Lane 0 perfect
      set_y(0, 42);
      arrow_active = 4'b0001;
      tick();
      press = 4'b0001;
      tick();
      press = 4'b0000;
      tick();
      chk("perf_hit", 32'(hit), 32'b0001);
      chk("perf_valid", 32'(grade_valid), 1);
      chk("perf_grade", 32'(grade), 3);
      chk("perf_score", 32'(score), 3);
      chk("perf_combo", 32'(combo), 1);
      tick();
      chk("perf_hit_pulse", 32'(hit), 0);
      chk("perf_maxc", 32'(max_combo), 1);

      // Lanes 1 and 2 good
      set_y(1, 50);
      set_y(2, 30);
      arrow_active = 4'b0111;
      tick();
      press = 4'b0110;
      tick();
      press = 4'b0000;
      tick();
      chk("good_hit", 32'(hit), 32'b0110);
      chk("good_grade", 32'(grade), 2);
      chk("good_score", 32'(score), 5);
      chk("good_combo", 32'(combo), 3);

      // Lane 3 frame miss
      set_y(3, 20);
      arrow_active = 4'b1111;
      tick();
      frame = 1'b1;
      tick();
      frame = 1'b0;
      tick();
      chk("miss_miss", 32'(miss), 32'b1000);
      chk("miss_hit", 32'(hit), 0);
      chk("miss_grade", 32'(grade), 1);
      chk("miss_combo", 32'(combo), 0);
      chk("miss_score", 32'(score), 5);
      tick();
      chk("miss_maxc", 32'(max_combo), 3);
      chk("miss_grade_idle", 32'(grade), 0);

      // Double press on lane 0
      arrow_active = 4'b0000;
      tick();
      arrow_active = 4'b0001;
      tick();
      press = 4'b0001;
      tick();
      tick();
      press = 4'b0000;
      chk("dbl_hit1", 32'(hit), 32'b0001);
      chk("dbl_score1", 32'(score), 8);
      tick();
      chk("dbl_hit2", 32'(hit), 0);
      chk("dbl_score2", 32'(score), 8);
      chk("dbl_combo", 32'(combo), 1);

      // Out-of-window press and press on an idle lane
      arrow_active = 4'b0000;
      tick();
      set_y(0, 100);
      arrow_active = 4'b0001;
      tick();
      press = 4'b0011;
      tick();
      press = 4'b0000;
      tick();
      chk("ign_hit", 32'(hit), 0);
      chk("ign_valid", 32'(grade_valid), 0);
      chk("ign_score", 32'(score), 8);
      chk("ign_combo", 32'(combo), 1);
      tick();
      chk("ign_hit_late", 32'(hit), 0);

      // Combo saturation
      arrow_active = 4'b0000;
      for (int l = 0; l < 4; l++) set_y(l, 42);
      tick();
      exp_score = 8;
      for (int r = 0; r < 64; r++) begin
         round(4'b1111);
         exp_score += 12;
      end
      chk("sat_combo", 32'(combo), 255);
      chk("sat_combo_score", 32'(score), 32'(exp_score));
      tick();
      chk("sat_maxc", 32'(max_combo), 255);

      // Score saturation
      while (exp_score + 12 <= 65534) begin
         round(4'b1111);
         exp_score += 12;
      end
      set_y(0, 50);
      while (exp_score < 65534) begin
         round(4'b0001);
         exp_score += 1;
      end
      chk("sat_score_near", 32'(score), 65534);
      set_y(0, 42);
      round(4'b0001);
      chk("sat_score_hit", 32'(hit), 32'b0001);
      chk("sat_score", 32'(score), 65535);
      chk("sat_combo_hold", 32'(combo), 255);

      // Reset one cycle after a press
      arrow_active = 4'b0001;
      tick();
      press = 4'b0001;
      tick();
      press = 4'b0000;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rstp_hit", 32'(hit), 0);
      chk("rstp_valid", 32'(grade_valid), 0);
      chk("rstp_score", 32'(score), 0);
      chk("rstp_combo", 32'(combo), 0);
      chk("rstp_maxc", 32'(max_combo), 0);
      tick();
      chk("rstp_hit_late", 32'(hit), 0);
      chk("rstp_grade_late", 32'(grade), 0);
      tick();
      chk("rstp_hit_late2", 32'(hit), 0);
      chk("rstp_score_late", 32'(score), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
